// File: rtl/regfile_write_queue_if.sv
//==============================================================================
// Module      : regfile_write_queue_if
// Description : Memory-path and ALU-path writeback handshakes into the
//               register-file write queue.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface regfile_write_queue_if;
    logic        mem_valid;
    logic [4:0]  mem_wn;
    logic [31:0] mem_wd;
    logic        mem_ready;
    logic        alu_valid;
    logic [4:0]  alu_wn;
    logic [31:0] alu_wd;
    logic        alu_ready;

    modport master (
        output mem_valid, mem_wn, mem_wd,
        input  mem_ready,
        output alu_valid, alu_wn, alu_wd,
        input  alu_ready
    );

    modport slave (
        input  mem_valid, mem_wn, mem_wd,
        output mem_ready,
        input  alu_valid, alu_wn, alu_wd,
        output alu_ready
    );
endinterface

`default_nettype wire

// File: rtl/regfile_write_queue.sv
//==============================================================================
// Module      : regfile_write_queue
// Description : In-order writeback queue draining one write per cycle into the
//               register file, with optional forwarding (macro WQ_FWD_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_write_queue #(
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    regfile_write_queue_if.slave          wq,
    output logic                          RegWrite,
    output logic [4:0]                    wn,
    output logic [31:0]                   wd,
    input  wire logic [4:0]               rs,
    input  wire logic [4:0]               rt,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output logic [31:0]                   fwd_data1,
    output logic [31:0]                   fwd_data2,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    logic [4:0]      r_q_wn [DEPTH];
    logic [31:0]     r_q_wd [DEPTH];
    logic [c_AW-1:0] r_head;
    logic [c_AW-1:0] r_tail;
    logic [c_CW-1:0] r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_regwrite;
    logic [4:0]      r_wn;
    logic [31:0]     r_wd;

    logic            w_mem_ready;
    logic            w_mem_acc;
    logic            w_alu_ready;
    logic            w_mem_push;
    logic            w_alu_push;
    logic            w_pop;
    logic [c_AW-1:0] w_alu_slot;
    logic [c_AW-1:0] w_tail_nxt;
    logic [c_CW-1:0] w_count_nxt;

    // Space is judged on the start-of-cycle count; a same-cycle pop never frees a slot.
    assign w_mem_ready = (r_count < c_DEPTH);
    assign w_mem_acc   = wq.mem_valid & w_mem_ready;
    assign w_alu_ready = (({1'b0, r_count} + (c_CW+1)'(w_mem_acc)) < (c_CW+1)'(DEPTH));

    // Writes to r0 complete the handshake but are never stored.
    assign w_mem_push  = w_mem_acc & (wq.mem_wn != 5'd0);
    assign w_alu_push  = wq.alu_valid & w_alu_ready & (wq.alu_wn != 5'd0);
    assign w_pop       = (r_count != '0);
    assign w_alu_slot  = r_tail + c_AW'(w_mem_push);
    assign w_tail_nxt  = w_alu_slot + c_AW'(w_alu_push);
    assign w_count_nxt = r_count + c_CW'(w_mem_push) + c_CW'(w_alu_push) - c_CW'(w_pop);

    assign wq.mem_ready = w_mem_ready;
    assign wq.alu_ready = w_alu_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_regwrite <= 1'b0;
            r_wn       <= '0;
            r_wd       <= '0;
        end else begin
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == c_DEPTH);
            r_empty    <= (w_count_nxt == '0);
            r_regwrite <= w_pop;
            if (w_pop) begin
                r_head <= r_head + c_AW'(1);
                r_wn   <= r_q_wn[r_head];
                r_wd   <= r_q_wd[r_head];
            end
        end
    end

    // The memory entry is the older instruction, so it takes the tail first.
    always_ff @(posedge clk) begin
        if (w_mem_push) begin
            r_q_wn[r_tail] <= wq.mem_wn;
            r_q_wd[r_tail] <= wq.mem_wd;
        end
        if (w_alu_push) begin
            r_q_wn[w_alu_slot] <= wq.alu_wn;
            r_q_wd[w_alu_slot] <= wq.alu_wd;
        end
    end

    assign RegWrite = r_regwrite;
    assign wn       = r_wn;
    assign wd       = r_wd;
    assign count    = r_count;
    assign full     = r_full;
    assign empty    = r_empty;

`ifdef WQ_FWD_EN
    for (genvar p = 0; p < 2; p++) begin : g_fwd_port
        logic [4:0]      w_addr;
        logic            w_hit;
        logic [31:0]     w_data;
        logic [c_AW-1:0] w_idx;

        assign w_addr = (p == 0) ? rs : rt;

        // Scan oldest to youngest so the youngest match is the one left standing.
        always_comb begin
            w_hit  = 1'b0;
            w_data = '0;
            w_idx  = '0;
            if (r_regwrite && (r_wn == w_addr)) begin
                w_hit  = 1'b1;
                w_data = r_wd;
            end
            for (int i = 0; i < DEPTH; i++) begin
                w_idx = r_head + c_AW'(i);
                if ((c_CW'(i) < r_count) && (r_q_wn[w_idx] == w_addr)) begin
                    w_hit  = 1'b1;
                    w_data = r_q_wd[w_idx];
                end
            end
            if (w_addr == 5'd0) begin
                w_hit  = 1'b0;
                w_data = '0;
            end
        end

        if (p == 0) begin : g_rs
            assign fwd_hit1  = w_hit;
            assign fwd_data1 = w_data;
        end else begin : g_rt
            assign fwd_hit2  = w_hit;
            assign fwd_data2 = w_data;
        end
    end
`else
    logic w_unused_addr;
    assign w_unused_addr = ^{rs, rt};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
//==============================================================================
// Module      : tb_regfile_write_queue
// Description : Directed self-checking bench for regfile_write_queue (DEPTH=4).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_write_queue;

`ifdef WQ_FWD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int n_chk  = 0;
    int n_fail = 0;

    regfile_write_queue_if bus ();

    regfile_write_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wq        (bus.slave),
        .RegWrite  (RegWrite),
        .wn        (wn),
        .wd        (wd),
        .rs        (rs),
        .rt        (rt),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mv, input logic [4:0] mwn, input logic [31:0] mwd,
                         input logic av, input logic [4:0] awn, input logic [31:0] awd);
        bus.mem_valid = mv;
        bus.mem_wn    = mwn;
        bus.mem_wd    = mwd;
        bus.alu_valid = av;
        bus.alu_wn    = awn;
        bus.alu_wd    = awd;
    endtask

    initial begin
        rst = 1'b1;
        rs  = 5'd0;
        rt  = 5'd0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_regwrite", 32'(RegWrite), 0);
        chk("rst_wn", 32'(wn), 0);
        chk("rst_wd", wd, 0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 1);
        chk("rst_fwd_hit1", 32'(fwd_hit1), 0);
        rst = 1'b0;

        // Single memory push: RegWrite two edges later, for one cycle.
        drive(1, 5, 32'h1234, 0, 0, 0);
        #1;
        chk("t1_mem_ready", 32'(bus.mem_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t1_count_after_push", 32'(count), 1);
        chk("t1_regwrite_early", 32'(RegWrite), 0);
        tick();
        chk("t1_regwrite", 32'(RegWrite), 1);
        chk("t1_wn", 32'(wn), 5);
        chk("t1_wd", wd, 32'h1234);
        chk("t1_count_drained", 32'(count), 0);
        tick();
        chk("t1_regwrite_off", 32'(RegWrite), 0);
        chk("t1_wn_hold", 32'(wn), 5);
        chk("t1_empty", 32'(empty), 1);

        // Same-cycle mem/ALU pushes to r3: ALU is younger and forwards.
        drive(1, 3, 32'hAAAA, 1, 3, 32'hBBBB);
        rs = 5'd3;
        rt = 5'd3;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t2_count", 32'(count), 2);
        chk("t2_fwd_hit1", 32'(fwd_hit1), 32'(c_FWD));
        chk("t2_fwd_data1_q", fwd_data1, c_FWD ? 32'hBBBB : 32'h0);
        chk("t2_fwd_data2_q", fwd_data2, c_FWD ? 32'hBBBB : 32'h0);
        tick();
        chk("t2_regwrite_a", 32'(RegWrite), 1);
        chk("t2_wd_a", wd, 32'hAAAA);
        chk("t2_fwd_data1_mix", fwd_data1, c_FWD ? 32'hBBBB : 32'h0);
        tick();
        chk("t2_regwrite_b", 32'(RegWrite), 1);
        chk("t2_wd_b", wd, 32'hBBBB);
        chk("t2_fwd_data1_out", fwd_data1, c_FWD ? 32'hBBBB : 32'h0);
        tick();
        chk("t2_regwrite_off", 32'(RegWrite), 0);
        chk("t2_fwd_hit1_off", 32'(fwd_hit1), 0);
        rs = 5'd0;
        rt = 5'd0;

        // Two writes per cycle: the drain pops every cycle, so count settles
        // at DEPTH-1 and the ALU path is throttled while memory keeps flowing.
        drive(1, 1, 32'h11, 1, 2, 32'h22);
        #1;
        chk("t3_a_alu_ready", 32'(bus.alu_ready), 1);
        tick();
        chk("t3_a_count", 32'(count), 2);
        drive(1, 3, 32'h33, 1, 4, 32'h44);
        #1;
        chk("t3_b_alu_ready", 32'(bus.alu_ready), 1);
        tick();
        chk("t3_b_count", 32'(count), 3);
        chk("t3_b_full", 32'(full), 0);
        chk("t3_b_wd", wd, 32'h11);
        drive(1, 5, 32'h55, 1, 6, 32'h66);
        #1;
        chk("t3_c_mem_ready", 32'(bus.mem_ready), 1);
        chk("t3_c_alu_ready", 32'(bus.alu_ready), 0);
        tick();
        chk("t3_c_count", 32'(count), 3);
        chk("t3_c_wd", wd, 32'h22);
        drive(1, 7, 32'h77, 1, 6, 32'h66);
        #1;
        chk("t3_d_alu_ready", 32'(bus.alu_ready), 0);
        tick();
        chk("t3_d_wd", wd, 32'h33);
        chk("t3_d_full", 32'(full), 0);
        drive(0, 0, 0, 1, 6, 32'h66);
        #1;
        chk("t3_e_alu_ready", 32'(bus.alu_ready), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t3_e_wd", wd, 32'h44);
        tick();
        chk("t3_wd_55", wd, 32'h55);
        tick();
        chk("t3_wd_77", wd, 32'h77);
        chk("t3_wn_7", 32'(wn), 7);
        tick();
        chk("t3_wd_66", wd, 32'h66);
        chk("t3_wn_6", 32'(wn), 6);
        chk("t3_count_end", 32'(count), 0);
        tick();
        chk("t3_regwrite_off", 32'(RegWrite), 0);

        // Writes to r0 handshake but leave no trace.
        drive(0, 0, 0, 1, 0, 32'hFFFF);
        #1;
        chk("t4_alu_ready", 32'(bus.alu_ready), 1);
        chk("t4_fwd_hit1_r0", 32'(fwd_hit1), 0);
        chk("t4_fwd_data1_r0", fwd_data1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_count", 32'(count), 0);
        tick();
        chk("t4_regwrite", 32'(RegWrite), 0);
        drive(1, 0, 32'hDEAD, 1, 9, 32'h99);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t4_mix_count", 32'(count), 1);
        tick();
        chk("t4_mix_wn", 32'(wn), 9);
        chk("t4_mix_wd", wd, 32'h99);
        tick();

        // Reset with three entries queued discards them.
        drive(1, 10, 32'hA0, 1, 11, 32'hA1);
        tick();
        drive(1, 12, 32'hA2, 1, 13, 32'hA3);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("t5_count_full3", 32'(count), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_count", 32'(count), 0);
        chk("t5_regwrite", 32'(RegWrite), 0);
        chk("t5_wn", 32'(wn), 0);
        chk("t5_wd", wd, 0);
        chk("t5_empty", 32'(empty), 1);
        tick();
        chk("t5_stale_1", 32'(RegWrite), 0);
        tick();
        chk("t5_stale_2", 32'(RegWrite), 0);
        chk("t5_count_after", 32'(count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
